uart_tx_serializer: RTL and testbench

UART_TX_SERIALIZER -- requirements
Module: uart_tx_serializer

---
 rtl/uart_pkg.sv | 13 +
 rtl/sync_fifo.sv | 46 ++++
 rtl/uart_tx_serializer.sv | 115 +++++++++++
 tb/tb_uart_tx_serializer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state encoding and frame constant for the UART transmitter
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int FRAME_BITS = 10;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock byte FIFO with wrap-bit pointers
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [AW:0]      o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_count   = r_wr_ptr - r_rd_ptr;
    assign o_full    = (o_count == (AW+1)'(DEPTH));
    assign o_empty   = (o_count == '0);
    assign o_data    = r_mem[r_rd_ptr[AW-1:0]];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // storage needs no reset; only entries between the pointers are ever read
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - buffered 8N1 UART transmitter with back-to-back framing
module uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8,
    localparam int CW          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          send_req,
    input  logic [7:0]    send_data,
    output logic          send_ready,
    output logic          uart_tx,
    output logic          busy,
    output logic [CW-1:0] fifo_count
);

    import uart_pkg::*;

    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    tx_state_t        r_state;
    tx_state_t        w_next_state;
    logic [CNT_W-1:0] r_clk_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_tx;
    logic             w_push;
    logic             w_pop;
    logic             w_bit_end;
    logic             w_full;
    logic             w_empty;
    logic [7:0]       w_head;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (send_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (fifo_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign send_ready = ~w_full;
    assign w_push     = send_req & send_ready;
    assign busy       = (r_state != IDLE) | ~w_empty;
    assign uart_tx    = r_tx;
    assign w_bit_end  = (r_clk_cnt == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_next_state = START;
                    w_pop        = 1'b1;
                end
            end
            START: if (w_bit_end) w_next_state = DATA;
            DATA:  if (w_bit_end && (r_bit_idx == 3'd7)) w_next_state = STOP;
            STOP: begin
                // chain straight into the next start bit so frames stay gapless
                if (w_bit_end) begin
                    if (!w_empty) begin
                        w_next_state = START;
                        w_pop        = 1'b1;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else if (w_pop) begin
            r_shift   <= w_head;
            r_tx      <= 1'b0;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
        end else if (r_state != IDLE) begin
            r_clk_cnt <= w_bit_end ? '0 : r_clk_cnt + 1'b1;
            if (w_bit_end) begin
                case (r_state)
                    START: r_tx <= r_shift[0];
                    DATA: begin
                        if (r_bit_idx == 3'd7) begin
                            r_tx <= 1'b1;
                        end else begin
                            r_tx      <= r_shift[1];
                            r_shift   <= r_shift >> 1;
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                    default: r_tx <= 1'b1;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - directed self-checking bench for uart_tx_serializer
module tb_uart_tx_serializer;

    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          send_req;
    logic [7:0]    send_data;
    logic          send_ready;
    logic          uart_tx;
    logic          busy;
    logic [CW-1:0] fifo_count;

    int   checks = 0;
    int   errors = 0;
    logic rec_on = 1'b0;
    logic rec_tx[$];
    logic rec_busy[$];
    logic [7:0] exp_q[$];

    uart_tx_serializer #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .send_req   (send_req),
        .send_data  (send_data),
        .send_ready (send_ready),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    // sample index 0 is the state just after the first edge following rec_on
    always @(posedge clk) begin
        #2;
        if (rec_on) begin
            rec_tx.push_back(uart_tx);
            rec_busy.push_back(busy);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [39:0] frame_bits(input logic [7:0] b);
        logic [39:0] r;
        for (int k = 0; k < 40; k++) begin
            int n;
            n = k / CPB;
            if (n == 0)      r[k] = 1'b0;
            else if (n == 9) r[k] = 1'b1;
            else             r[k] = b[n-1];
        end
        return r;
    endfunction

    function automatic logic at_tx(input int i);
        return (i < rec_tx.size()) ? rec_tx[i] : 1'bx;
    endfunction

    function automatic logic at_busy(input int i);
        return (i < rec_busy.size()) ? rec_busy[i] : 1'bx;
    endfunction

    task automatic start_rec();
        rec_tx.delete();
        rec_busy.delete();
        rec_on = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 2000; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        check({tag, " idle reached"}, busy, 1'b0);
        repeat (2) @(negedge clk);
        rec_on = 1'b0;
    endtask

    // frames are expected contiguously from sample 1 (START entered one edge after accept)
    task automatic check_frames(input string tag, input logic [7:0] bytes[$]);
        logic [39:0] obs;
        int          last;
        for (int f = 0; f < bytes.size(); f++) begin
            for (int k = 0; k < 40; k++) obs[k] = at_tx(1 + 40 * f + k);
            check($sformatf("%s frame%0d", tag, f), obs, frame_bits(bytes[f]));
        end
        last = 1 + 40 * bytes.size();
        check({tag, " busy in last stop"}, at_busy(last - 1), 1'b1);
        check({tag, " busy after frames"}, at_busy(last), 1'b0);
        check({tag, " line high after"}, at_tx(last), 1'b1);
    endtask

    initial begin
        int zeros;
        int busies;
        rst       = 1'b1;
        send_req  = 1'b0;
        send_data = 8'h00;

        repeat (3) @(negedge clk);
        check("reset uart_tx", uart_tx, 1'b1);
        check("reset fifo_count", fifo_count, 4'd0);
        check("reset send_ready", send_ready, 1'b1);
        check("reset busy", busy, 1'b0);

        // single byte, requested on the first edge after reset release
        rst = 1'b0;
        start_rec();
        send_req  = 1'b1;
        send_data = 8'h55;
        @(negedge clk);
        send_req = 1'b0;
        check("t1 tx high after accept", uart_tx, 1'b1);
        check("t1 count after accept", fifo_count, 4'd1);
        check("t1 busy after accept", busy, 1'b1);
        @(negedge clk);
        check("t1 tx low after 2nd edge", uart_tx, 1'b0);
        check("t1 count after pop", fifo_count, 4'd0);
        wait_idle("t1");
        exp_q.delete();
        exp_q.push_back(8'h55);
        check_frames("t1", exp_q);

        // two bytes on consecutive cycles
        @(negedge clk);
        start_rec();
        send_req  = 1'b1;
        send_data = 8'h48;
        @(negedge clk);
        send_data = 8'h69;
        @(negedge clk);
        send_req = 1'b0;
        check("t2 count push+pop", fifo_count, 4'd1);
        check("t2 tx start", uart_tx, 1'b0);
        wait_idle("t2");
        exp_q.delete();
        exp_q.push_back(8'h48);
        exp_q.push_back(8'h69);
        check_frames("t2", exp_q);

        // overflow: twelve requests, nine accepted
        @(negedge clk);
        start_rec();
        for (int i = 0; i < 12; i++) begin
            check($sformatf("t3 send_ready req%0d", i), send_ready, (i < 9) ? 1'b1 : 1'b0);
            if (i == 9) check("t3 count full", fifo_count, 4'd8);
            send_req  = 1'b1;
            send_data = 8'h10 + 8'(i);
            @(negedge clk);
        end
        send_req = 1'b0;
        check("t3 count after burst", fifo_count, 4'd8);
        wait_idle("t3");
        exp_q.delete();
        for (int i = 0; i < 9; i++) exp_q.push_back(8'h10 + 8'(i));
        check_frames("t3", exp_q);

        // reset mid-frame during data bit 3 of 0xA5 with three bytes queued
        @(negedge clk);
        send_req  = 1'b1;
        send_data = 8'hA5;
        @(negedge clk);
        send_data = 8'h01;
        @(negedge clk);
        send_data = 8'h02;
        @(negedge clk);
        send_data = 8'h03;
        @(negedge clk);
        send_req = 1'b0;
        check("t4 count buffered", fifo_count, 4'd3);
        repeat (15) @(negedge clk);
        check("t4 tx data bit3", uart_tx, 1'b0);
        check("t4 count before rst", fifo_count, 4'd3);
        #1 rst = 1'b1;
        #1;
        check("t4 rst uart_tx", uart_tx, 1'b1);
        check("t4 rst fifo_count", fifo_count, 4'd0);
        check("t4 rst send_ready", send_ready, 1'b1);
        check("t4 rst busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        start_rec();
        repeat (60) @(negedge clk);
        rec_on = 1'b0;
        zeros  = 0;
        busies = 0;
        foreach (rec_tx[i]) if (rec_tx[i] !== 1'b1) zeros++;
        foreach (rec_busy[i]) if (rec_busy[i] !== 1'b0) busies++;
        check("t4 line low samples after rst", zeros, 0);
        check("t4 busy samples after rst", busies, 0);

        // push landing on the stop-to-start pop edge
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start_rec();
        send_req  = 1'b1;
        send_data = 8'h3C;
        @(negedge clk);
        send_data = 8'hC3;
        @(negedge clk);
        send_req = 1'b0;
        check("t5 count one queued", fifo_count, 4'd1);
        repeat (39) @(negedge clk);
        check("t5 tx last stop cycle", uart_tx, 1'b1);
        check("t5 count before pop edge", fifo_count, 4'd1);
        send_req  = 1'b1;
        send_data = 8'h7E;
        @(negedge clk);
        send_req = 1'b0;
        check("t5 count after push+pop", fifo_count, 4'd1);
        check("t5 tx second start", uart_tx, 1'b0);
        wait_idle("t5");
        exp_q.delete();
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        exp_q.push_back(8'h7E);
        check_frames("t5", exp_q);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
